exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Parametrised multi-cycle execution unit, next generation of the single-cycle ALU/FPU result path.
- Accepts one operation at a time over a valid/ready handshake.
- ALU ops finish in 1 cycle; iterative multiply and divide take WIDTH cycles.
- Registered result and NZCV flags are held until the consumer takes them; sits between the register-read stage and result/write-back mux of the multicycle core.

Parameters:
- WIDTH, 32: operand/result width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, do not override.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request present.
- in_ready  output  1  unit can accept a request this cycle.
- op  input  3  operation code, see Behaviour.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result this cycle.
- result  output  WIDTH  operation result.
- flags  output  4  {N,Z,C,V}.
- busy  output  1  high while in MUL or DIV state.

Behaviour:
- Opcodes:
  - 000 ADD, 001 SUB (a-b), 010 AND, 011 ORR: single-cycle.
  - 100 MUL: low WIDTH bits of a*b, unsigned.
  - 101 UDIV: quotient. 110 UREM: remainder.
  - 111 reserved: result 0, flags 0100, single-cycle.
- Reset (reset==0, asynchronous): state=IDLE; out_valid=0; result=0; flags=0; busy=0; counter=0. Any in-flight op is discarded. in_ready=1 from the first edge after release.
- Accept rule: transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready). Operands and op are latched on transfer.
- States:
  - IDLE: single-cycle op -> result/flags registered, out_valid=1 next cycle, stays IDLE. MUL -> MUL state. DIV/REM -> DIV state.
  - MUL: shift-add, one bit of b per cycle, LSB first.
  - DIV: restoring division, one quotient bit per cycle, MSB first.
  - MUL/DIV run for WIDTH cycles, counter 0..WIDTH-1. Then -> DONE.
  - DONE: load result/flags, out_valid=1, -> IDLE.
- Latency: accept at edge T -> single-cycle out_valid at T+1; MUL/DIV out_valid at T+WIDTH+1.
- Result buffer is single-entry:
  - out_valid, result and flags are held stable until out_valid && out_ready.
  - out_valid clears the cycle after that handshake unless a new single-cycle op is accepted in the same cycle; then the new result loads back-to-back.
  - No transfer while out_valid && !out_ready.
- Flags:
  - N = result[WIDTH-1]; Z = (result==0).
  - C: ADD carry-out; SUB = (a>=b) unsigned; else 0.
  - V: ADD/SUB signed overflow; MUL = 1 if upper WIDTH bits of full product nonzero; DIV/REM = 1 if b==0; else 0.
- Divide by zero: quotient = all ones, remainder = a, V=1. Still takes full latency.
- Operand inputs are ignored outside accept cycles; changing them mid-operation has no effect.

Optional Feature:
- EXEC_UNIT_DIV_EN defined: UDIV/UREM as above, DIV state present.
- Undefined: no DIV state or divider datapath. Opcodes 101/110 behave as reserved: single-cycle, result 0, flags 0100.

Test Plan:
- ADD a=0x7FFFFFFF b=1, out_ready=1 -> next cycle result 0x80000000, flags N=1 Z=0 C=0 V=1; in_ready stays 1.
- SUB a=5 b=5, then back-to-back ORR a=0xF0 b=0x0F with out_ready=1 -> result 0 flags 0110, then 0xFF flags 0000 on consecutive cycles.
- MUL a=0x10000 b=0x10000 -> busy for 32 cycles, out_valid at T+33, result 0, flags Z=1 V=1; in_ready=0 throughout.
- UDIV a=100 b=7 then UREM same operands -> 14 (flags 0000) and 2; UDIV b=0 -> 0xFFFFFFFF, V=1, N=1.
- Hold out_ready=0 after ADD 3+4 for 5 cycles -> result 7 stable, out_valid=1, in_ready=0; raise out_ready -> out_valid drops next cycle.
- Assert reset low at cycle 10 of a MUL -> outputs immediately zero; after release a new ADD 1+1 returns 2 at T+1.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: multi-cycle integer execution unit with a single-entry result buffer.
//
// Accepts one operation at a time over a valid/ready handshake. ADD/SUB/AND/ORR
// and the reserved opcodes complete in one cycle. MUL (shift-add, LSB first) and,
// when EXEC_UNIT_DIV_EN is defined, UDIV/UREM (restoring, MSB first) iterate for
// WIDTH cycles. Result and NZCV flags are held until the consumer takes them.
//
// Optional feature macro: EXEC_UNIT_DIV_EN
//   defined   -> DIV state and divider datapath present (opcodes 101/110)
//   undefined -> 101/110 behave as reserved (single-cycle, result 0, flags 0100)
//
// Ports:
//   clk        clock, all state changes on rising edge
//   reset      asynchronous active-low reset
//   in_valid   request present          in_ready  unit can accept this cycle
//   op         operation code           a, b      operands
//   out_valid  result/flags valid       out_ready consumer takes result
//   result     operation result         flags     {N,Z,C,V}
//   busy       high while iterating (MUL or DIV state)
module exec_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
`ifdef EXEC_UNIT_DIV_EN
    localparam logic [2:0] OP_UDIV = 3'b101;
    localparam logic [2:0] OP_UREM = 3'b110;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;       // MUL: upper partial product; DIV: partial remainder
    logic [WIDTH-1:0] lo;       // MUL: multiplier / low product; DIV: dividend / quotient
    logic [WIDTH-1:0] opa;      // multiplicand
    logic             started;  // holds in_ready low until the first edge after reset
`ifdef EXEC_UNIT_DIV_EN
    logic [WIDTH-1:0] opb;      // divisor
    logic             op_rem;   // 1: deliver remainder, 0: quotient
    logic [WIDTH:0]   shifted;
    logic             div_ok;
`endif

    logic             accept;
    logic             is_multi;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [WIDTH:0]   add_s, sub_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo, fin_res;
    logic             fin_v;

    always_comb begin
        in_ready = started && (state == S_IDLE) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
`ifdef EXEC_UNIT_DIV_EN
        busy     = (state == S_MUL) || (state == S_DIV);
        is_multi = (op == OP_MUL) || (op == OP_UDIV) || (op == OP_UREM);
`else
        busy     = (state == S_MUL);
        is_multi = (op == OP_MUL);
`endif
    end

    // Single-cycle ops. Unlisted opcodes fall to the reserved result (0, Z only).
    always_comb begin
        add_s   = {1'b0, a} + {1'b0, b};
        sub_d   = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_s[WIDTH-1:0];
                alu_c   = add_s[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_d[WIDTH-1:0];
                alu_c   = !sub_d[WIDTH];  // no borrow means a >= b
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_ORR:  alu_res = a | b;
            default: alu_res = '0;
        endcase
    end

    // One iteration step, plus the final result taken straight from the last step
    // so the result register loads on the same edge as the final iteration.
    always_comb begin
        mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? opa : {WIDTH{1'b0}})};
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        fin_res = step_lo;
        fin_v   = |step_hi;
`ifdef EXEC_UNIT_DIV_EN
        shifted = {hi, lo[WIDTH-1]};
        div_ok  = (shifted >= {1'b0, opb});
        if (state == S_DIV) begin
            // A trial remainder below the divisor always fits WIDTH bits, so the
            // subtraction can be done on the low WIDTH bits only.
            step_hi = div_ok ? (shifted[WIDTH-1:0] - opb) : shifted[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], div_ok};
            fin_res = op_rem ? step_hi : step_lo;
            fin_v   = (opb == '0);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            opa       <= '0;
            started   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
`ifdef EXEC_UNIT_DIV_EN
            opb       <= '0;
            op_rem    <= 1'b0;
`endif
        end else begin
            started <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (out_valid && out_ready)
                        out_valid <= 1'b0;
                    if (accept) begin
                        if (is_multi) begin
                            opa <= a;
                            hi  <= '0;
                            cnt <= '0;
`ifdef EXEC_UNIT_DIV_EN
                            opb    <= b;
                            op_rem <= (op == OP_UREM);
                            lo     <= (op == OP_MUL) ? b : a;
                            state  <= (op == OP_MUL) ? S_MUL : S_DIV;
`else
                            lo    <= b;
                            state <= S_MUL;
`endif
                        end else begin
                            result    <= alu_res;
                            flags     <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
                            out_valid <= 1'b1;
                        end
                    end
                end
`ifdef EXEC_UNIT_DIV_EN
                S_MUL, S_DIV: begin
`else
                S_MUL: begin
`endif
                    hi <= step_hi;
                    lo <= step_lo;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cnt       <= '0;
                        result    <= fin_res;
                        flags     <= {fin_res[WIDTH-1], fin_res == '0, 1'b0, fin_v};
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // One settle cycle; the result may already be consumed here.
                S_DONE: begin
                    if (out_valid && out_ready)
                        out_valid <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  a = '0, b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic [3:0]    flags;
    logic          busy;

    int nchecks = 0;
    int nerrs   = 0;

    exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit multi_op(input logic [2:0] o);
`ifdef EXEC_UNIT_DIV_EN
        return (o == 3'd4) || (o == 3'd5) || (o == 3'd6);
`else
        return (o == 3'd4);
`endif
    endfunction

    // Returns {N,Z,C,V, result} from plain arithmetic.
    function automatic logic [35:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint      s;
        logic [31:0] r;
        logic        c, v;
        r = '0; c = 1'b0; v = 1'b0; p = '0; s = 0;
        case (o)
            3'd0: begin
                p = {32'b0, x} + {32'b0, y};
                r = p[31:0]; c = p[32];
                s = longint'($signed(x)) + longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = x - y; c = (x >= y);
                s = longint'($signed(x)) - longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: begin
                p = {32'b0, x} * {32'b0, y};
                r = p[31:0]; v = (p[63:32] != 0);
            end
`ifdef EXEC_UNIT_DIV_EN
            3'd5: begin r = (y == 0) ? 32'hFFFF_FFFF : x / y; v = (y == 0); end
            3'd6: begin r = (y == 0) ? x : x % y;            v = (y == 0); end
`endif
            default: r = '0;
        endcase
        return {r[31], (r == 0), c, v, r};
    endfunction

    // Transaction-level model: which result is visible, when the unit accepts,
    // and when an iterative op completes.
    bit          m_valid = 0, pend = 0, started = 0;
    logic [31:0] m_res = '0, p_res = '0;
    logic [3:0]  m_flags = '0, p_flags = '0;
    int          cyc = 0, due = 0, done_cyc = -1;

    function automatic bit exp_ready();
        return started && !pend && (cyc != done_cyc) && (!m_valid || out_ready);
    endfunction

    initial forever begin
        bit rdy, acc, cons;
        logic [35:0] rv;
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_valid = 0; pend = 0; started = 0; m_res = '0; m_flags = '0; done_cyc = -1;
        end else begin
            rdy  = exp_ready();
            acc  = in_valid && rdy;
            cons = m_valid && out_ready;
            cyc++;
            started = 1;
            if (pend && cyc == due) begin
                m_valid = 1; m_res = p_res; m_flags = p_flags; pend = 0; done_cyc = cyc;
            end else begin
                if (cons) m_valid = 0;
                if (acc) begin
                    rv = ref_op(op, a, b);
                    if (multi_op(op)) begin
                        pend = 1; due = cyc + W; p_res = rv[31:0]; p_flags = rv[35:32];
                    end else begin
                        m_valid = 1; m_res = rv[31:0]; m_flags = rv[35:32];
                    end
                end
            end
        end
    end

    // Compare DUT to model every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_result", result, 0);
            chk("rst_flags", {28'b0, flags}, 0);
            chk("rst_busy", {31'b0, busy}, 0);
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready()});
            chk("busy", {31'b0, busy}, {31'b0, (pend && cyc < due)});
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("result", result, m_res);
                chk("flags", {28'b0, flags}, {28'b0, m_flags});
            end
        end
    end

    // ---------------- stimulus ----------------
    // Issues one request; n returns edges from accept to out_valid (1 = next cycle).
    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
        @(posedge clk); #1;
        in_valid = 1; op = o; a = x; b = y;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 100);
        if (!in_ready) begin
            chk("accept", {31'b0, in_ready}, 1);
            in_valid = 0; n = -1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 0; op = 3'($urandom); a = $urandom; b = $urandom;
        n = 1;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [3:0] ef, input int lat);
        int n;
        send(o, x, y, n);
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_result"}, result, er);
        chk({nm, "_flags"}, {28'b0, flags}, {28'b0, ef});
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1;

        // Single-cycle ops with hand-computed expectations.
        do_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, 1);
        do_op("sub_borrow", 3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000, 1);
        do_op("sub_ovf", 3'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011, 1);
        do_op("and", 3'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000, 1);
        do_op("rsvd", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'b0100, 1);

        // Back-to-back SUB then ORR.
        @(posedge clk); #1;
        in_valid = 1; op = 3'd1; a = 32'd5; b = 32'd5;
        @(negedge clk); chk("b2b_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        op = 3'd3; a = 32'h0000_00F0; b = 32'h0000_000F;
        @(negedge clk);
        chk("b2b_sub_result", result, 32'h0);
        chk("b2b_sub_flags", {28'b0, flags}, 32'b0110);
        @(posedge clk); #1;
        in_valid = 0;
        chk("b2b_orr_valid", {31'b0, out_valid}, 1);
        chk("b2b_orr_result", result, 32'h0000_00FF);
        chk("b2b_orr_flags", {28'b0, flags}, 32'b0000);

        // Iterative ops.
        do_op("mul_wrap", 3'd4, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b0101, W + 1);
        do_op("mul_small", 3'd4, 32'd1234, 32'd5678, 32'd7006652, 4'b0000, W + 1);
`ifdef EXEC_UNIT_DIV_EN
        do_op("udiv", 3'd5, 32'd100, 32'd7, 32'd14, 4'b0000, W + 1);
        do_op("urem", 3'd6, 32'd100, 32'd7, 32'd2, 4'b0000, W + 1);
        do_op("udiv_zero", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 4'b1001, W + 1);
        do_op("urem_zero", 3'd6, 32'd100, 32'd0, 32'd100, 4'b0001, W + 1);
`else
        do_op("udiv_rsvd", 3'd5, 32'd100, 32'd7, 32'h0, 4'b0100, 1);
        do_op("urem_rsvd", 3'd6, 32'd100, 32'd7, 32'h0, 4'b0100, 1);
`endif

        // Result held while the consumer stalls.
        @(posedge clk); #1 out_ready = 0;
        do_op("hold_add", 3'd0, 32'd3, 32'd4, 32'd7, 4'b0000, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, out_valid}, 1);
            chk("hold_result", result, 32'd7);
            chk("hold_ready", {31'b0, in_ready}, 0);
        end
        @(posedge clk); #1 out_ready = 1;
        @(posedge clk); #1;
        chk("hold_release", {31'b0, out_valid}, 0);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        in_valid = 1; op = 3'd4; a = 32'hDEAD_BEEF; b = 32'h0000_00FF;
        @(negedge clk); chk("rst_mul_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1 in_valid = 0;
        repeat (10) @(posedge clk);
        #1 reset = 0;
        #1;
        chk("rst_now_valid", {31'b0, out_valid}, 0);
        chk("rst_now_busy", {31'b0, busy}, 0);
        chk("rst_now_result", result, 0);
        @(posedge clk); #1 reset = 1;
        do_op("post_rst_add", 3'd0, 32'd1, 32'd1, 32'd2, 4'b0000, 1);

        // Mixed traffic checked against the model, with occasional stalls.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            out_ready = (i % 4 != 3);
            send(3'($urandom_range(0, 7)), x, y, n);
            @(posedge clk); #1 out_ready = 1;
        end
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
